pio_poll_master: RTL



---
 rtl/pio_poll_master.sv | 90 +++++++++
 1 files changed

// File: rtl/pio_poll_master.sv
// pio_poll_master: periodic Avalon-MM reader of an input PIO with debounced value and change pulse
module pio_poll_master #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PIO_ADDR = '0,
  parameter int DATA_WIDTH = 8,
  parameter int POLL_PERIOD = 1000,
  parameter int STABLE_COUNT = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic [ADDR_WIDTH-1:0] avm_address,
  output logic                  avm_read,
  input  logic                  avm_waitrequest,
  input  logic [31:0]           avm_readdata,
  input  logic                  avm_readdatavalid,
  output logic [DATA_WIDTH-1:0] value,
  output logic                  value_valid,
  output logic                  change,
  output logic                  timeout_err,
  output logic [7:0]            err_count
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2;
  localparam int PW = $clog2(POLL_PERIOD);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [1:0] state;
  logic [PW-1:0] timer;
  logic [TW-1:0] to_cnt;
  logic pending, expire, got, to_hit, accept, unused_data;
  logic [DATA_WIDTH-1:0] cand, sample;
  logic [3:0] stable, stable_n;
  assign avm_address = PIO_ADDR;
  assign avm_read = state == REQ;
  assign expire = enable && timer == PW'(POLL_PERIOD - 1);
  assign sample = avm_readdata[DATA_WIDTH-1:0];
  assign unused_data = ^(avm_readdata >> DATA_WIDTH);
  assign got = state == RESP && avm_readdatavalid;
  assign to_hit = state == RESP && !avm_readdatavalid && to_cnt == TW'(TIMEOUT - 1);
  assign stable_n = sample != cand ? 4'd1 : stable == 4'(STABLE_COUNT) ? stable : stable + 4'd1;
  assign accept = got && stable_n == 4'(STABLE_COUNT) && (!value_valid || sample != value);
  // free-running poll period timer, frozen while polling is disabled
  always_ff @(posedge clk or posedge reset)
    if (reset) timer <= '0;
    else if (enable) timer <= expire ? '0 : timer + PW'(1);
  // remember one expiry that lands while a transaction is still in flight
  always_ff @(posedge clk or posedge reset)
    if (reset) pending <= 1'b0;
    else pending <= state != IDLE && (pending || expire);
  // transaction sequencing: issue read, hold until accepted, wait for response or timeout
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      to_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (expire || pending) state <= REQ;
        REQ: if (!avm_waitrequest) begin
          state <= RESP;
          to_cnt <= '0;
        end
        RESP: if (got || to_hit) state <= IDLE;
              else to_cnt <= to_cnt + TW'(1);
        default: state <= IDLE;
      endcase
    end
  // debounce samples and publish accepted value, change and timeout pulses
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cand <= '0;
      stable <= '0;
      value <= '0;
      value_valid <= 1'b0;
      change <= 1'b0;
      timeout_err <= 1'b0;
      err_count <= '0;
    end else begin
      change <= accept;
      timeout_err <= to_hit;
      if (to_hit && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (got) begin
        cand <= sample;
        stable <= stable_n;
      end
      if (accept) begin
        value <= sample;
        value_valid <= 1'b1;
      end
    end
endmodule
